// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the memory bus interface stage.
package cpu_bus_pkg;

    localparam int BUS_W  = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2,
        ST_WR_WAIT  = 2'd3
    } mbi_state_t;

    // True while the stage is waiting on mem_ready.
    function automatic logic is_wait_state(input mbi_state_t s);
        return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
    endfunction

endpackage

// File: rtl/mem_bus_if_wait_timer.sv
// Wait-cycle counter for memory transactions: cleared while idle, counts
// cycles without mem_ready, and flags the cycle whose increment would reach
// LIMIT so the caller can abandon the transaction at that edge.
module wait_timer #(
    parameter int LIMIT = 15,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A mem_ready in this cycle suppresses inc, so a late ready still wins.
    assign expire = inc && (cnt_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_if.sv
// Memory bus interface stage feeding the 8-bit data register.
// Optional feature: define MEM_TIMEOUT_EN to abort transactions whose
// mem_ready does not arrive within TIMEOUT wait cycles (reported on err).
module mem_bus_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [15:0]       addr,
    input  logic [7:0]        wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       bus_out,
    output logic              bus_oe,
    output logic              drload,
    output logic              busy,
    output logic              done,
    output logic              err
);

    mbi_state_t state_r;
    logic       timer_expire_s;

`ifdef MEM_TIMEOUT_EN
    logic timer_clear_s;
    logic timer_inc_s;

    assign timer_clear_s = (state_r == ST_IDLE);
    assign timer_inc_s   = is_wait_state(state_r) && !mem_ready;

    wait_timer #(
        .LIMIT (TIMEOUT),
        .CNT_W (8)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_s),
        .inc    (timer_inc_s),
        .expire (timer_expire_s)
    );
`else
    // No timer: waits never expire (TIMEOUT is always >= 1).
    assign timer_expire_s = (TIMEOUT == 0);
`endif

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= 8'h00;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            bus_out   <= 16'h0000;
            bus_oe    <= 1'b0;
            drload    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (read_req) begin
                        // Read wins a simultaneous request; the write is dropped.
                        mem_addr <= addr[ADDR_W-1:0];
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= ST_RD_WAIT;
                    end else if (write_req) begin
                        mem_addr  <= addr[ADDR_W-1:0];
                        mem_wdata <= wdata;
                        mem_wr    <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_WR_WAIT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_ready) begin
                        bus_out <= {{(BUS_W-DATA_W){1'b0}}, mem_rdata};
                        mem_rd  <= 1'b0;
                        bus_oe  <= 1'b1;
                        drload  <= 1'b1;
                        state_r <= ST_RD_DRIVE;
                    end else if (timer_expire_s) begin
                        mem_rd  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_RD_DRIVE: begin
                    // Single cycle in which the data register captures bus_out.
                    bus_oe  <= 1'b0;
                    drload  <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_WR_WAIT: begin
                    if (mem_ready) begin
                        mem_wr  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (timer_expire_s) begin
                        mem_wr  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WR_WAIT;
                    end
                end
                default: begin
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    bus_oe  <= 1'b0;
                    drload  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed self-checking bench for mem_bus_if with a read/done scoreboard.
module tb_mem_bus_if;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        drload;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rd_q[$];
    logic        done_q[$];
    logic [15:0] mon_bus;
    logic        mon_err;
    logic [8:0]  exp_done;

    always #5 clk = ~clk;

    mem_bus_if #(.ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_req  (read_req),
        .write_req (write_req),
        .addr      (addr),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .drload    (drload),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: drload pops the expected read byte, done pops err.
    always @(negedge clk) begin
        check("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
        if (drload) begin
            if (rd_q.size() == 0) begin
                check("drload_unexpected", 32'd1, 32'd0);
            end else begin
                mon_bus = rd_q.pop_front();
                check("sb_bus_out", {16'd0, bus_out}, {16'd0, mon_bus});
                check("sb_bus_oe", {31'd0, bus_oe}, 32'd1);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                mon_err = done_q.pop_front();
                check("sb_err", {31'd0, err}, {31'd0, mon_err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_strobes", {29'd0, mem_rd, mem_wr, bus_oe}, 32'd0);
        check("rst_bus_out", {16'd0, bus_out}, 32'd0);
        check("rst_flags", {28'd0, drload, busy, done, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read at 0x0042 returning 0xA5
        addr = 16'h0042; read_req = 1'b1;
        @(negedge clk);
        check("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
        check("rd_mem_addr", {16'd0, mem_addr}, 32'h0042);
        check("rd_busy", {31'd0, busy}, 32'd1);
        check("rd_no_drload", {31'd0, drload}, 32'd0);
        read_req = 1'b0; mem_ready = 1'b1; mem_rdata = 8'hA5;
        rd_q.push_back(16'h00A5); done_q.push_back(1'b0);
        @(negedge clk);
        check("rd_drload", {30'd0, drload, bus_oe}, 32'd3);
        check("rd_bus_out", {16'd0, bus_out}, 32'h00A5);
        check("rd_mem_rd_off", {31'd0, mem_rd}, 32'd0);
        check("rd_done_early", {31'd0, done}, 32'd0);
        mem_ready = 1'b0; mem_rdata = 8'h00;
        @(negedge clk);
        check("rd_drload_off", {30'd0, drload, bus_oe}, 32'd0);
        check("rd_done", {31'd0, done}, 32'd1);
        check("rd_busy_off", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rd_done_pulse", {31'd0, done}, 32'd0);

        // Write 0x3C to 0x0010 with mem_ready delayed three cycles
        addr = 16'h0010; wdata = 8'h3C; write_req = 1'b1;
        done_q.push_back(1'b0);
        @(negedge clk);
        write_req = 1'b0; wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
            check("wr_mem_wdata", {24'd0, mem_wdata}, 32'h3C);
            check("wr_mem_addr", {16'd0, mem_addr}, 32'h0010);
            check("wr_no_done", {31'd0, done}, 32'd0);
            check("wr_no_drload", {31'd0, drload}, 32'd0);
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        check("wr_mem_wr_off", {31'd0, mem_wr}, 32'd0);
        check("wr_done", {31'd0, done}, 32'd1);
        check("wr_drload", {31'd0, drload}, 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);

        // Simultaneous requests: read wins, write dropped
        addr = 16'h0077; wdata = 8'hFF; read_req = 1'b1; write_req = 1'b1;
        @(negedge clk);
        check("both_mem_rd", {31'd0, mem_rd}, 32'd1);
        check("both_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("both_mem_wdata", {24'd0, mem_wdata}, 32'h3C);
        read_req = 1'b0; write_req = 1'b0; mem_ready = 1'b1; mem_rdata = 8'h5A;
        rd_q.push_back(16'h005A); done_q.push_back(1'b0);
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 8'h00;
        check("both_drload", {31'd0, drload}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("both_no_wr", {31'd0, mem_wr}, 32'd0);
        end
        @(negedge clk);

        // Held read_req with zero-wait memory: done every 3 cycles
        exp_done = 9'b000100100;
        rd_q.push_back(16'h00C3); rd_q.push_back(16'h00C3);
        done_q.push_back(1'b0); done_q.push_back(1'b0);
        addr = 16'h0200; mem_rdata = 8'hC3; mem_ready = 1'b1; read_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 6) read_req = 1'b0;
            check("b2b_done", {31'd0, done}, {31'd0, exp_done[i-1]});
        end
        mem_ready = 1'b0; mem_rdata = 8'h00;

        // Reset during RD_WAIT aborts the read
        addr = 16'h0123; read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("abort_waiting", {30'd0, mem_rd, busy}, 32'd3);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        check("abort_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("abort_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("abort_bus_out", {16'd0, bus_out}, 32'd0);
        check("abort_outs", {25'd0, mem_rd, mem_wr, bus_oe, drload, busy, done, err}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_quiet", {29'd0, drload, done, busy}, 32'd0);
        end
        mem_ready = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Timeout: mem_ready never arrives
        addr = 16'h0300; read_req = 1'b1;
        done_q.push_back(1'b1);
        @(negedge clk);
        read_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_mem_rd", {31'd0, mem_rd}, 32'd1);
            check("to_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("to_mem_rd_off", {31'd0, mem_rd}, 32'd0);
        check("to_done_err", {30'd0, done, err}, 32'd3);
        check("to_no_drive", {30'd0, drload, bus_oe}, 32'd0);
        @(negedge clk);
        check("to_pulse", {30'd0, done, err}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("sb_rd_empty", rd_q.size(), 32'd0);
        check("sb_done_empty", done_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
